// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and command modes for the MAC unit sequencer
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    RUN,
    DRAIN,
    OUT
  } seq_state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/mac_index_counter.sv
// rtl/mac_index_counter.sv - element index k with last-element flag and next address
module mac_index_counter #(
  parameter int ADDR_BITS = 8,
  parameter int LEN_BITS  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic [LEN_BITS-1:0]  len_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [ADDR_BITS-1:0] next_addr_o,
  output logic                 last_o
);

  // One spare bit so a full-depth vector never wraps k back to zero.
  localparam int K_BITS = ADDR_BITS + 1;

  logic [K_BITS-1:0] k_q, k_d;
  logic [K_BITS-1:0] len_m1;

  assign len_m1 = K_BITS'(len_i) - K_BITS'(1);

  always_comb begin
    k_d = k_q;
    if (clear_i) begin
      k_d = '0;
    end else if (inc_i) begin
      k_d = k_q + K_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign last_o = (k_q == len_m1);
  assign addr_o = k_q[ADDR_BITS-1:0];
  // Hold on the final element so no address past len-1 is ever issued.
  assign next_addr_o = last_o ? k_q[ADDR_BITS-1:0] : k_q[ADDR_BITS-1:0] + ADDR_BITS'(1);

endmodule

// File: rtl/mac_unit_sequencer.sv
// rtl/mac_unit_sequencer.sv - drives one MAC hidden unit for weight load and dot-product runs
module mac_unit_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BRAM_DEPTH  = 256,
  parameter int W_ADDR_BITS = $clog2(BRAM_DEPTH),
  parameter int LEN_BITS    = $clog2(BRAM_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_mode,
  input  logic [LEN_BITS-1:0]    cfg_len,
  output logic                   cfg_err,
  output logic                   busy,
  output logic                   done,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   u_clear,
  output logic                   u_enable,
  output logic                   u_write_enable,
  output logic [W_ADDR_BITS-1:0] u_address,
  output logic [DATA_WIDTH-1:0]  u_data,
  input  logic [DATA_WIDTH-1:0]  u_result,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data
);

  seq_state_t            state_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  cfg_err_q;

  logic                   len_ok, accept, fire, last;
  logic [W_ADDR_BITS-1:0] k_addr, k_next_addr;

  assign len_ok = (cfg_len != '0) &&
                  ({1'b0, cfg_len} <= (LEN_BITS + 1)'(BRAM_DEPTH));
  assign accept = (state_q == IDLE) && cfg_start && len_ok;
  assign fire   = s_valid && s_ready;

  mac_index_counter #(
    .ADDR_BITS (W_ADDR_BITS),
    .LEN_BITS  (LEN_BITS)
  ) u_index (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (accept),
    .inc_i       (fire),
    .len_i       (len_q),
    .addr_o      (k_addr),
    .next_addr_o (k_next_addr),
    .last_o      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      m_data_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && cfg_start && !len_ok;
      unique case (state_q)
        IDLE: if (accept) begin
          len_q   <= cfg_len;
          state_q <= (cfg_mode == MODE_RUN) ? PRIME : LOAD;
        end
        LOAD:  if (fire && last) state_q <= IDLE;
        PRIME: state_q <= RUN;
        RUN:   if (fire && last) state_q <= DRAIN;
        // Accumulator has absorbed the last product by now.
        DRAIN: begin
          m_data_q <= u_result;
          state_q  <= OUT;
        end
        OUT:     if (m_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready        = (state_q == LOAD) || (state_q == RUN);
    u_clear        = (state_q == PRIME);
    u_enable       = (state_q == RUN) && fire;
    u_write_enable = (state_q == LOAD) && fire;
    u_data         = s_ready ? s_data : '0;
    u_address      = '0;
    // In RUN the address leads k on a fire so W[k+1] is read in time for the next beat.
    if (state_q == LOAD) begin
      u_address = k_addr;
    end else if (state_q == RUN) begin
      u_address = fire ? k_next_addr : k_addr;
    end
  end

  assign busy    = (state_q != IDLE);
  assign m_valid = (state_q == OUT);
  assign m_data  = m_data_q;
  assign cfg_err = cfg_err_q;
  assign done    = ((state_q == LOAD) && fire && last) || ((state_q == OUT) && m_ready);

endmodule

// File: tb/tb_mac_unit_sequencer.sv
// tb/tb_mac_unit_sequencer.sv - sequencer driving a behavioural unit memory and accumulator
module tb_mac_unit_sequencer;

  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int AW = 8;
  localparam int LB = 9;

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_mode;
  logic [LB-1:0] cfg_len;
  logic cfg_err, busy, done;
  logic s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic u_clear, u_enable, u_write_enable;
  logic [AW-1:0] u_address;
  logic [DW-1:0] u_data, u_result;
  logic m_valid, m_ready;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  mac_unit_sequencer #(
    .DATA_WIDTH (DW),
    .BRAM_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_mode       (cfg_mode),
    .cfg_len        (cfg_len),
    .cfg_err        (cfg_err),
    .busy           (busy),
    .done           (done),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .u_clear        (u_clear),
    .u_enable       (u_enable),
    .u_write_enable (u_write_enable),
    .u_address      (u_address),
    .u_data         (u_data),
    .u_result       (u_result),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data)
  );

  // Hidden unit: synchronous-read weight memory feeding a clearable accumulator.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] acc = '0;
  assign u_result = acc;

  always @(posedge clk) begin
    if (u_write_enable) mem[u_address] <= u_data;
    rd_q <= mem[u_address];
    if (u_clear) acc <= '0;
    else if (u_enable) acc <= acc + u_data * rd_q;
  end

  int total = 0;
  int bad = 0;
  int done_cnt = 0, err_cnt = 0, clear_cnt = 0, en_cnt = 0, skip_cnt = 0, res_seen = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [AW-1:0] prev_addr = '0;
  bit have_prev = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tb_w [DEPTH];
  logic [DW-1:0] tb_x [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cfg_err) err_cnt++;
    if (u_clear) clear_cnt++;
    if (u_enable) en_cnt++;
    if (u_write_enable) last_wr_addr = u_address;
    if (busy && s_ready && !u_write_enable) begin
      if (have_prev && u_address !== prev_addr && u_address !== prev_addr + 8'd1) skip_cnt++;
      prev_addr = u_address;
      have_prev = 1;
    end else if (!busy) begin
      have_prev = 0;
    end
    if (m_valid && m_ready) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_result", m_data, exp_q.pop_front());
      res_seen++;
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic mode, input int len);
    cfg_start = 1'b1;
    cfg_mode = mode;
    cfg_len = LB'(len);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, output int waits);
    bit fired;
    fired = 0;
    waits = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!fired && waits < 64) begin
      @(negedge clk);
      fired = s_ready;
      @(posedge clk);
      #1;
      if (!fired) waits++;
    end
    s_valid = 1'b0;
    s_data = '0;
    check("beat_fire", fired, 1);
  endtask

  task automatic wait_result(input int target);
    int c;
    c = 0;
    while (res_seen < target && c < 600) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("result_seen", res_seen, target);
  endtask

  task automatic do_load(input int len);
    int d0, c0, waits;
    d0 = done_cnt;
    c0 = clear_cnt;
    send_cmd(1'b0, len);
    for (int i = 0; i < len; i++) begin
      push_beat(tb_w[i], waits);
      if (i == 0) check("load_latency", waits, 0);
    end
    settle();
    check("load_done", done_cnt - d0, 1);
    check("load_no_clear", clear_cnt - c0, 0);
    check("load_idle", busy, 0);
  endtask

  task automatic do_run(input int len, input int gap, input bit bp);
    int d0, c0, e0, r0, waits, c;
    logic [DW-1:0] sum, md;
    sum = '0;
    for (int i = 0; i < len; i++) sum = sum + tb_w[i] * tb_x[i];
    exp_q.push_back(sum);
    d0 = done_cnt;
    c0 = clear_cnt;
    e0 = en_cnt;
    r0 = res_seen;
    skip_cnt = 0;
    if (bp) m_ready = 1'b0;
    send_cmd(1'b1, len);
    for (int i = 0; i < len; i++) begin
      push_beat(tb_x[i], waits);
      if (i == 0) check("run_latency", waits, 1);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    if (bp) begin
      c = 0;
      while (!m_valid && c < 20) begin
        @(posedge clk);
        #1;
        c++;
      end
      check("out_latency", c, 1);
      md = m_data;
      check("bp_data", md, sum);
      for (int j = 0; j < 5; j++) begin
        if (j == 2) begin
          cfg_start = 1'b1;
          cfg_mode = 1'b0;
          cfg_len = LB'(2);
        end
        @(negedge clk);
        check("bp_valid", m_valid, 1);
        check("bp_stable", m_data, md);
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
      end
      m_ready = 1'b1;
      cfg_start = 1'b1;
      @(negedge clk);
      check("bp_done", done, 1);
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      @(negedge clk);
      check("bp_no_accept", {busy, s_ready}, 0);
    end
    wait_result(r0 + 1);
    settle();
    check("run_done", done_cnt - d0, 1);
    check("run_clear", clear_cnt - c0, 1);
    check("run_enables", en_cnt - e0, len);
    check("run_no_skip", skip_cnt, 0);
  endtask

  initial begin
    int e0, d0, waits;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_mode = 1'b0;
    cfg_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {busy, done, cfg_err, s_ready, u_clear, u_enable, u_write_enable, m_valid, u_address, u_data}, 0);
    check("reset_m_data", m_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tb_w[i] = DW'(i + 1);
      tb_x[i] = DW'(i + 5);
    end
    do_load(4);
    do_run(4, 0, 0);
    check("dot_70", m_data, 70);

    for (int i = 0; i < 3; i++) begin
      tb_w[i] = 2;
      tb_x[i] = 1;
    end
    do_load(3);
    do_run(3, 2, 0);
    check("stall_6", m_data, 6);

    for (int i = 0; i < 3; i++) tb_x[i] = DW'(i + 1);
    do_run(3, 0, 1);

    e0 = err_cnt;
    send_cmd(1'b0, 0);
    @(negedge clk);
    check("len0_busy", busy, 0);
    #1;
    check("len0_err", err_cnt - e0, 1);
    e0 = err_cnt;
    send_cmd(1'b1, DEPTH + 1);
    @(negedge clk);
    check("len257_busy", busy, 0);
    @(negedge clk);
    #1;
    check("len257_err", err_cnt - e0, 1);

    for (int i = 0; i < DEPTH; i++) begin
      tb_w[i] = 1;
      tb_x[i] = 1;
    end
    do_load(DEPTH);
    check("full_last_addr", last_wr_addr, DEPTH - 1);
    do_run(DEPTH, 0, 0);
    check("full_dot", m_data, DEPTH);

    d0 = done_cnt;
    send_cmd(1'b1, 4);
    push_beat(32'd3, waits);
    push_beat(32'd3, waits);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ctrl", {busy, done, cfg_err, s_ready, u_clear, u_enable, u_write_enable, m_valid, u_address, u_data}, 0);
    check("rst_mid_m_data", m_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    check("rst_mid_no_done", done_cnt - d0, 0);

    tb_w[0] = 1;
    tb_x[0] = 9;
    do_load(1);
    do_run(1, 0, 0);
    check("fresh_9", m_data, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mac_unit_sequencer.md
# mac_unit_sequencer

Sequencer that drives the weight-memory and accumulator port of one MAC hidden unit from a single valid/ready input stream. It loads a weight vector into the unit's memory, or streams an activation vector through the unit and returns the finished dot product on a valid/ready result port. It sits between the layer DMA/stream fabric and each hidden unit: it generates the unit's clear, enable, write_enable, address and data_in, and reads back the unit's data_out.

## Interface
- DATA_WIDTH, 32: stream, weight and result width
- BRAM_DEPTH, 256: unit weight-memory depth
- W_ADDR_BITS, $clog2(BRAM_DEPTH): unit address width
- LEN_BITS, $clog2(BRAM_DEPTH+1): vector-length field width
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle command strobe
- cfg_mode  in  1  0 = LOAD weights, 1 = RUN dot product
- cfg_len  in  LEN_BITS  vector length, legal range 1..BRAM_DEPTH
- cfg_err  out  1  one-cycle pulse when a command is rejected
- busy  out  1  high from command acceptance until the command completes
- done  out  1  one-cycle pulse at completion
- s_valid / s_ready  in / out  1  input stream handshake
- s_data  in  DATA_WIDTH  weight or activation beat
- u_clear, u_enable, u_write_enable  out  1  unit controls
- u_address  out  W_ADDR_BITS  unit memory address
- u_data  out  DATA_WIDTH  unit data_in
- u_result  in  DATA_WIDTH  unit data_out
- m_valid / m_ready  out / in  1  result handshake
- m_data  out  DATA_WIDTH  captured result

## Operation
- States: IDLE, LOAD, PRIME, RUN, DRAIN, OUT.
- IDLE:
  - cfg_start with cfg_len in 1..BRAM_DEPTH is accepted: latch len and mode, zero the index k, raise busy.
  - Mode 0 goes to LOAD. Mode 1 goes to PRIME.
  - cfg_len = 0 or cfg_len > BRAM_DEPTH: pulse cfg_err, stay in IDLE.
  - cfg_start while busy is ignored, with no error pulse.
- LOAD:
  - s_ready = 1. On each fire (s_valid & s_ready): u_write_enable = 1, u_address = k, u_data = s_data, then k++.
  - The fire with k = len-1 pulses done and returns to IDLE.
- PRIME (exactly one cycle): u_clear = 1, u_address = 0, s_ready = 0. Next state is RUN.
- RUN:
  - s_ready = 1, u_data = s_data, u_enable = fire.
  - u_address = fire ? k+1 : k (combinational), so the synchronous-read weight W[k] is present in the cycle element k fires.
  - The fire with k = len-1 goes to DRAIN. No address is issued beyond len-1.
- DRAIN (one cycle): capture u_result into m_data. Next state is OUT.
- OUT:
  - m_valid = 1 and m_data holds stable until m_ready.
  - On the m_valid & m_ready handshake: pulse done, drop busy, return to IDLE.
- In IDLE, LOAD, OUT and DRAIN, u_enable = u_clear = 0. Outside LOAD, u_write_enable = 0.
- Address arithmetic: k is W_ADDR_BITS+1 wide. len = BRAM_DEPTH writes addresses 0..BRAM_DEPTH-1 with no wrap.

## Timing
- Reset values: all outputs 0, state IDLE, m_data 0.
- Reset asserted mid-command:
  - Next cycle the block is in IDLE with all outputs 0 and any partial result is discarded.
  - A partial LOAD leaves earlier-written weights in memory.
- Latencies:
  - Command accept to first s_ready: 1 cycle for LOAD, 2 cycles for RUN (PRIME in between).
  - Last RUN beat (cycle t): unit accumulator settles at t+1 (DRAIN), m_valid rises at t+2.
- s_valid may drop for any number of cycles in LOAD or RUN. The stall leaves k, u_address and the unit untouched.
- cfg_start in the same cycle as done is ignored (busy is still high).

## Structure
- Package mac_pkg holds:
  - seq_state_t enum (IDLE, LOAD, PRIME, RUN, DRAIN, OUT)
  - constants MODE_LOAD = 1'b0 and MODE_RUN = 1'b1
- Sub-module mac_index_counter holds the index logic: a k register with clear, increment-on-fire, a last flag (k == len-1) and a next-address output.
- This block, the unit's memory and MAC are instantiated side by side in the bench.

## Test plan
- Load then run: LOAD len=4, weights 1,2,3,4; RUN activations 5,6,7,8. Required: m_data = 70, done pulses once per command, u_clear high only in PRIME.
- Stalled stream: RUN len=3 with s_valid low for 2 cycles between each beat, weights 2,2,2, inputs 1,1,1. Required: m_data = 6, u_address never skips, u_enable count = 3.
- Result backpressure: hold m_ready = 0 for 5 cycles. Required: m_valid and m_data stable throughout, no new cfg_start accepted.
- Bad length: cfg_len = 0 and cfg_len = BRAM_DEPTH+1. Required: cfg_err pulses once, busy stays 0.
- Full depth: LOAD len = BRAM_DEPTH with weights all 1, then RUN inputs all 1. Required: last write address = BRAM_DEPTH-1, m_data = BRAM_DEPTH.
- Reset mid-RUN: assert rst after 2 of 4 beats. Required: next cycle state IDLE, all outputs 0. A fresh RUN len=1 (w0=1, input 9) yields m_data = 9.
